// File: rtl/write_back_buffer.sv
// Write-back buffer: absorbs dirty evictions from the LRU cache, merges repeat
// evictions of the same tag, drains them one at a time to lower memory over a
// req/ack handshake, and offers a combinational forwarding lookup.
module write_back_buffer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_WIDTH   = 2,
    parameter int unsigned VALUE_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evict_valid,
    input  logic [TAG_WIDTH-1:0]     evict_tag,
    input  logic [VALUE_WIDTH-1:0]   evict_value,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     mem_req,
    output logic [TAG_WIDTH-1:0]     mem_tag,
    output logic [VALUE_WIDTH-1:0]   mem_value,
    input  logic                     mem_ack,
    input  logic [TAG_WIDTH-1:0]     lookup_tag,
    output logic                     lookup_hit,
    output logic [VALUE_WIDTH-1:0]   lookup_value
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0]       vld_q;
    logic [TAG_WIDTH-1:0]   tag_q [DEPTH];
    logic [VALUE_WIDTH-1:0] val_q [DEPTH];
    logic [PTR_W-1:0]       head_q, tail_q;
    logic [CNT_W-1:0]       count_q;

    logic                   co_hit;
    logic [PTR_W-1:0]       co_idx;
    logic                   pop, push_app, drop;
    logic                   mem_req_d;
    logic [TAG_WIDTH-1:0]   mem_tag_d;
    logic [VALUE_WIDTH-1:0] mem_value_d;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Coalesce match: find a pending entry with the evicted tag, skipping the in-flight head
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (tag_q[i] == evict_tag) &&
                !((state_q == BUSY) && (PTR_W'(i) == head_q))) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    assign pop      = (state_q == BUSY) && mem_ack;
    assign push_app = evict_valid && !co_hit && (!full || pop);
    assign drop     = evict_valid && !co_hit && full && !pop;

    // Forwarding lookup: head match first, any younger match overrides it
    always_comb begin
        lookup_hit   = 1'b0;
        lookup_value = '0;
        if (vld_q[head_q] && (tag_q[head_q] == lookup_tag)) begin
            lookup_hit   = 1'b1;
            lookup_value = val_q[head_q];
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (tag_q[i] == lookup_tag) && (PTR_W'(i) != head_q)) begin
                lookup_hit   = 1'b1;
                lookup_value = val_q[i];
            end
        end
    end

    // Drain FSM next state and request outputs; a same-edge merge into the head is forwarded
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req;
        mem_tag_d   = mem_tag;
        mem_value_d = mem_value;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_tag_d   = tag_q[head_q];
                    mem_value_d = (evict_valid && co_hit && (co_idx == head_q)) ?
                                  evict_value : val_q[head_q];
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request registers, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_tag   <= '0;
            mem_value <= '0;
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req   <= mem_req_d;
            mem_tag   <= mem_tag_d;
            mem_value <= mem_value_d;
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (push_app) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            count_q <= count_q + CNT_W'(push_app) - CNT_W'(pop);
        end
    end

    // Entry payload storage: append at tail or merge in place
    always_ff @(posedge clk) begin
        if (evict_valid && co_hit) begin
            val_q[co_idx] <= evict_value;
        end
        if (push_app) begin
            tag_q[tail_q] <= evict_tag;
            val_q[tail_q] <= evict_value;
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// Bench for write_back_buffer: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model.
module tb_write_back_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 2;
    localparam int unsigned VW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          evict_valid;
    logic [TW-1:0] evict_tag;
    logic [VW-1:0] evict_value;
    logic          full, empty, overflow;
    logic [2:0]    count;
    logic          mem_req;
    logic [TW-1:0] mem_tag;
    logic [VW-1:0] mem_value;
    logic          mem_ack;
    logic [TW-1:0] lookup_tag;
    logic          lookup_hit;
    logic [VW-1:0] lookup_value;

    write_back_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .VALUE_WIDTH(VW)) dut (
        .clk(clk), .rst(rst),
        .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_value(evict_value),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .mem_req(mem_req), .mem_tag(mem_tag), .mem_value(mem_value), .mem_ack(mem_ack),
        .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_value(lookup_value)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [TW-1:0]    mq_tag[$];
    logic [VW-1:0]    mq_val[$];
    bit               m_busy;
    bit               m_ovf;
    logic [TW-1:0]    m_tag;
    logic [VW-1:0]    m_val;
    logic [TW+VW-1:0] wlog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_tag.delete();
        mq_val.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        m_tag  = '0;
        m_val  = '0;
    endtask

    task automatic model_edge(input bit ev, input logic [TW-1:0] t, input logic [VW-1:0] v,
                              input bit ack);
        bit pop;
        int hit;
        int n;
        pop = m_busy && ack;
        hit = -1;
        n   = mq_tag.size();
        if (ev) begin
            for (int i = (m_busy ? 1 : 0); i < n; i++)
                if (mq_tag[i] == t) hit = i;
            if (hit >= 0) mq_val[hit] = v;
        end
        if (pop) begin
            void'(mq_tag.pop_front());
            void'(mq_val.pop_front());
            m_busy = 1'b0;
        end else if (!m_busy && n > 0) begin
            m_busy = 1'b1;
            m_tag  = mq_tag[0];
            m_val  = mq_val[0];
        end
        if (ev && hit < 0) begin
            if (n < int'(DEPTH) || pop) begin
                mq_tag.push_back(t);
                mq_val.push_back(v);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit            hit;
        logic [VW-1:0] val;
        hit = 1'b0;
        val = '0;
        for (int i = mq_tag.size() - 1; i >= 0; i--) begin
            if (!hit && mq_tag[i] == lookup_tag) begin
                hit = 1'b1;
                val = mq_val[i];
            end
        end
        check("mem_req",   64'(mem_req),   64'(m_busy));
        check("mem_tag",   64'(mem_tag),   64'(m_tag));
        check("mem_value", 64'(mem_value), 64'(m_val));
        check("count",     64'(count),     64'(mq_tag.size()));
        check("full",      64'(full),      64'(mq_tag.size() == int'(DEPTH)));
        check("empty",     64'(empty),     64'(mq_tag.size() == 0));
        check("overflow",  64'(overflow),  64'(m_ovf));
        check("lk_hit",    64'(lookup_hit),   64'(hit));
        check("lk_value",  64'(lookup_value), 64'(val));
    endtask

    // one clock: apply inputs, log accepted write-backs, advance model, compare
    task automatic cycle(input bit ev, input logic [TW-1:0] t, input logic [VW-1:0] v,
                         input bit ack);
        evict_valid = ev;
        evict_tag   = t;
        evict_value = v;
        mem_ack     = ack;
        #1;
        if (mem_req && mem_ack) wlog.push_back({mem_tag, mem_value});
        @(posedge clk);
        model_edge(ev, t, v, ack);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        evict_valid = 1'b0;
        mem_ack     = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, '0, '0, m_busy);
    endtask

    initial begin
        rst         = 1'b1;
        evict_valid = 1'b0;
        evict_tag   = '0;
        evict_value = '0;
        mem_ack     = 1'b0;
        lookup_tag  = '0;
        model_reset();

        // reset state and lookup on an empty buffer
        do_reset();
        lookup_tag = 2'd3;
        #1;
        check("empty_lk_hit", 64'(lookup_hit), 64'd0);
        check("empty_lk_val", 64'(lookup_value), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);

        // in-order drain of three evictions
        lookup_tag = 2'd1;
        cycle(1'b1, 2'd1, 32'hA, 1'b0);
        cycle(1'b1, 2'd2, 32'hB, 1'b0);
        cycle(1'b1, 2'd3, 32'hC, 1'b0);
        check("t1_count3", 64'(count), 64'd3);
        drain(10);
        check("t1_log_n", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            check("t1_w0", 64'(wlog[0]), 64'({2'd1, 32'hA}));
            check("t1_w1", 64'(wlog[1]), 64'({2'd2, 32'hB}));
            check("t1_w2", 64'(wlog[2]), 64'({2'd3, 32'hC}));
        end
        check("t1_empty", 64'(empty), 64'd1);

        // coalescing behind an in-flight entry of the same tag
        do_reset();
        lookup_tag = 2'd2;
        cycle(1'b1, 2'd2, 32'h11, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 1'b0);
        cycle(1'b1, 2'd2, 32'h22, 1'b0);
        check("t2_count_a", 64'(count), 64'd2);
        cycle(1'b1, 2'd2, 32'h33, 1'b0);
        check("t2_count_b", 64'(count), 64'd2);
        check("t2_lk_hit", 64'(lookup_hit), 64'd1);
        check("t2_lk_val", 64'(lookup_value), 64'h33);
        drain(8);
        check("t2_log_n", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check("t2_w0", 64'(wlog[0]), 64'({2'd2, 32'h11}));
            check("t2_w1", 64'(wlog[1]), 64'({2'd2, 32'h33}));
        end

        // full, drop with overflow, then push accepted alongside a pop
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, TW'(i), 32'h50 + 32'(i), 1'b0);
        check("t3_full", 64'(full), 64'd1);
        cycle(1'b1, 2'd0, 32'h55, 1'b0);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_count_a", 64'(count), 64'd4);
        lookup_tag = 2'd0;
        cycle(1'b1, 2'd0, 32'h66, 1'b1);
        check("t3_count_b", 64'(count), 64'd4);
        check("t3_ovf_hold", 64'(overflow), 64'd1);
        check("t3_lk_val", 64'(lookup_value), 64'h66);
        drain(12);

        // pointer wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, TW'(i), 32'h100 + 32'(i), m_busy);
            cycle(1'b0, '0, '0, m_busy);
            cycle(1'b0, '0, '0, m_busy);
        end
        drain(6);
        check("t4_log_n", 64'(wlog.size()), 64'd10);
        for (int i = 0; i < wlog.size() && i < 10; i++)
            check("t4_w", 64'(wlog[i]), 64'({TW'(i), 32'h100 + 32'(i)}));

        // asynchronous reset during an in-flight request
        do_reset();
        lookup_tag = 2'd3;
        cycle(1'b1, 2'd3, 32'h77, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        check("t5_req_pre", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_req_async", 64'(mem_req), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_lk_hit", 64'(lookup_hit), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
        check("t5_no_stale", 64'(wlog.size()), 64'd0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            lookup_tag = TW'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)));
        end
        drain(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
